// File: rtl/vfr_nn.sv
// 2-4-10 fixed-point MLP: ReLU hidden layer, linear output layer, two register stages.
// Optional VFR_NN_ROUND_EN: round half up before each rescale instead of floor.
module vfr_nn #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] f1_input1, f2_input2,
    input  logic signed [WIDTH-1:0] h1_w1, h1_w2, h1_bias,
    input  logic signed [WIDTH-1:0] h2_w1, h2_w2, h2_bias,
    input  logic signed [WIDTH-1:0] h3_w1, h3_w2, h3_bias,
    input  logic signed [WIDTH-1:0] h4_w1, h4_w2, h4_bias,
    input  logic signed [WIDTH-1:0] out_w11, out_w12, out_w13, out_w14,
    input  logic signed [WIDTH-1:0] out_w21, out_w22, out_w23, out_w24,
    input  logic signed [WIDTH-1:0] out_w31, out_w32, out_w33, out_w34,
    input  logic signed [WIDTH-1:0] out_w41, out_w42, out_w43, out_w44,
    input  logic signed [WIDTH-1:0] out_w51, out_w52, out_w53, out_w54,
    input  logic signed [WIDTH-1:0] out_w61, out_w62, out_w63, out_w64,
    input  logic signed [WIDTH-1:0] out_w71, out_w72, out_w73, out_w74,
    input  logic signed [WIDTH-1:0] out_w81, out_w82, out_w83, out_w84,
    input  logic signed [WIDTH-1:0] out_w91, out_w92, out_w93, out_w94,
    input  logic signed [WIDTH-1:0] out_w101, out_w102, out_w103, out_w104,
    input  logic signed [WIDTH-1:0] out_bias1, out_bias2, out_bias3, out_bias4, out_bias5,
    input  logic signed [WIDTH-1:0] out_bias6, out_bias7, out_bias8, out_bias9, out_bias10,
    output logic signed [WIDTH-1:0] net_output1, net_output2, net_output3, net_output4,
    output logic signed [WIDTH-1:0] net_output5, net_output6, net_output7, net_output8,
    output logic signed [WIDTH-1:0] net_output9, net_output10
);

    localparam int ACC = 2*WIDTH + 3;
    typedef logic signed [ACC-1:0] acc_t;

    localparam acc_t SAT_MAX = acc_t'(2**(WIDTH-1) - 1);
    localparam acc_t SAT_MIN = acc_t'(-(2**(WIDTH-1)));
    localparam acc_t RND     = acc_t'(1) <<< (FRAC-1);

    function automatic acc_t sx(input logic signed [WIDTH-1:0] v);
        return $signed({{(ACC-WIDTH){v[WIDTH-1]}}, v});
    endfunction

    // Arithmetic shift floors toward -inf; rounding adds half an LSB first.
    function automatic logic signed [WIDTH-1:0] rescale(input acc_t a);
        acc_t s;
`ifdef VFR_NN_ROUND_EN
        s = (a + RND) >>> FRAC;
`else
        s = a >>> FRAC;
`endif
        if (s > SAT_MAX)
            return SAT_MAX[WIDTH-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[WIDTH-1:0];
        else
            return s[WIDTH-1:0];
    endfunction

    logic signed [WIDTH-1:0] w_hw1 [4];
    logic signed [WIDTH-1:0] w_hw2 [4];
    logic signed [WIDTH-1:0] w_hb  [4];
    logic signed [WIDTH-1:0] w_ow  [10][4];
    logic signed [WIDTH-1:0] w_ob  [10];

    assign w_hw1 = '{h1_w1, h2_w1, h3_w1, h4_w1};
    assign w_hw2 = '{h1_w2, h2_w2, h3_w2, h4_w2};
    assign w_hb  = '{h1_bias, h2_bias, h3_bias, h4_bias};
    assign w_ow  = '{'{out_w11, out_w12, out_w13, out_w14},
                     '{out_w21, out_w22, out_w23, out_w24},
                     '{out_w31, out_w32, out_w33, out_w34},
                     '{out_w41, out_w42, out_w43, out_w44},
                     '{out_w51, out_w52, out_w53, out_w54},
                     '{out_w61, out_w62, out_w63, out_w64},
                     '{out_w71, out_w72, out_w73, out_w74},
                     '{out_w81, out_w82, out_w83, out_w84},
                     '{out_w91, out_w92, out_w93, out_w94},
                     '{out_w101, out_w102, out_w103, out_w104}};
    assign w_ob  = '{out_bias1, out_bias2, out_bias3, out_bias4, out_bias5,
                     out_bias6, out_bias7, out_bias8, out_bias9, out_bias10};

    logic signed [WIDTH-1:0] r_h      [4];
    logic signed [WIDTH-1:0] r_out    [10];
    logic signed [WIDTH-1:0] w_h_nxt  [4];
    logic signed [WIDTH-1:0] w_o_nxt  [10];
    logic signed [WIDTH-1:0] w_h_sat;
    acc_t                    w_acc_h;
    acc_t                    w_acc_o;

    always_comb begin
        w_acc_h = '0;
        w_h_sat = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            w_acc_h = sx(f1_input1) * sx(w_hw1[k]) + sx(f2_input2) * sx(w_hw2[k])
                    + (sx(w_hb[k]) <<< FRAC);
            w_h_sat = rescale(w_acc_h);
            // ReLU after saturation keeps the hidden range at [0, max].
            w_h_nxt[k] = w_h_sat[WIDTH-1] ? '0 : w_h_sat;
        end
    end

    always_comb begin
        w_acc_o = '0;
        for (int unsigned j = 0; j < 10; j++) begin
            w_acc_o = sx(w_ob[j]) <<< FRAC;
            for (int unsigned k = 0; k < 4; k++)
                w_acc_o = w_acc_o + sx(r_h[k]) * sx(w_ow[j][k]);
            w_o_nxt[j] = rescale(w_acc_o);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < 4; k++)  r_h[k]   <= '0;
            for (int unsigned j = 0; j < 10; j++) r_out[j] <= '0;
        end else begin
            for (int unsigned k = 0; k < 4; k++)  r_h[k]   <= w_h_nxt[k];
            for (int unsigned j = 0; j < 10; j++) r_out[j] <= w_o_nxt[j];
        end
    end

    assign net_output1  = r_out[0];
    assign net_output2  = r_out[1];
    assign net_output3  = r_out[2];
    assign net_output4  = r_out[3];
    assign net_output5  = r_out[4];
    assign net_output6  = r_out[5];
    assign net_output7  = r_out[6];
    assign net_output8  = r_out[7];
    assign net_output9  = r_out[8];
    assign net_output10 = r_out[9];

endmodule

// File: tb/tb_vfr_nn.sv
// Directed self-checking bench for vfr_nn (Q8.8); expectations are hand-computed.
module tb_vfr_nn;

    logic                clk;
    logic                rst;
    logic signed [15:0]  f1, f2;
    logic signed [15:0]  hw1 [4];
    logic signed [15:0]  hw2 [4];
    logic signed [15:0]  hb  [4];
    logic signed [15:0]  ow  [10][4];
    logic signed [15:0]  ob  [10];
    logic signed [15:0]  no  [10];

    int n_cmp = 0;
    int n_err = 0;

    vfr_nn #(.WIDTH(16), .FRAC(8)) dut (
        .clk(clk), .rst(rst), .f1_input1(f1), .f2_input2(f2),
        .h1_w1(hw1[0]), .h1_w2(hw2[0]), .h1_bias(hb[0]),
        .h2_w1(hw1[1]), .h2_w2(hw2[1]), .h2_bias(hb[1]),
        .h3_w1(hw1[2]), .h3_w2(hw2[2]), .h3_bias(hb[2]),
        .h4_w1(hw1[3]), .h4_w2(hw2[3]), .h4_bias(hb[3]),
        .out_w11(ow[0][0]), .out_w12(ow[0][1]), .out_w13(ow[0][2]), .out_w14(ow[0][3]),
        .out_w21(ow[1][0]), .out_w22(ow[1][1]), .out_w23(ow[1][2]), .out_w24(ow[1][3]),
        .out_w31(ow[2][0]), .out_w32(ow[2][1]), .out_w33(ow[2][2]), .out_w34(ow[2][3]),
        .out_w41(ow[3][0]), .out_w42(ow[3][1]), .out_w43(ow[3][2]), .out_w44(ow[3][3]),
        .out_w51(ow[4][0]), .out_w52(ow[4][1]), .out_w53(ow[4][2]), .out_w54(ow[4][3]),
        .out_w61(ow[5][0]), .out_w62(ow[5][1]), .out_w63(ow[5][2]), .out_w64(ow[5][3]),
        .out_w71(ow[6][0]), .out_w72(ow[6][1]), .out_w73(ow[6][2]), .out_w74(ow[6][3]),
        .out_w81(ow[7][0]), .out_w82(ow[7][1]), .out_w83(ow[7][2]), .out_w84(ow[7][3]),
        .out_w91(ow[8][0]), .out_w92(ow[8][1]), .out_w93(ow[8][2]), .out_w94(ow[8][3]),
        .out_w101(ow[9][0]), .out_w102(ow[9][1]), .out_w103(ow[9][2]), .out_w104(ow[9][3]),
        .out_bias1(ob[0]), .out_bias2(ob[1]), .out_bias3(ob[2]), .out_bias4(ob[3]),
        .out_bias5(ob[4]), .out_bias6(ob[5]), .out_bias7(ob[6]), .out_bias8(ob[7]),
        .out_bias9(ob[8]), .out_bias10(ob[9]),
        .net_output1(no[0]), .net_output2(no[1]), .net_output3(no[2]), .net_output4(no[3]),
        .net_output5(no[4]), .net_output6(no[5]), .net_output7(no[6]), .net_output8(no[7]),
        .net_output9(no[8]), .net_output10(no[9])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic zero_all();
        f1 = '0;
        f2 = '0;
        for (int k = 0; k < 4; k++) begin
            hw1[k] = '0; hw2[k] = '0; hb[k] = '0;
        end
        for (int j = 0; j < 10; j++) begin
            ob[j] = '0;
            for (int k = 0; k < 4; k++) ow[j][k] = '0;
        end
    endtask

    logic [15:0] thr_in  [7];
    logic [15:0] mix_exp [10];

    initial begin
        thr_in  = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0000, 16'h0000};
        // h = {1.0, 2.0, 1.0, 0.5}; output j picks h[j%4] and adds raw bias j
        mix_exp = '{16'h0100, 16'h0201, 16'h0102, 16'h0083, 16'h0104,
                    16'h0205, 16'h0106, 16'h0087, 16'h0108, 16'h0209};

        rst = 1'b0;
        zero_all();
        tick();
        tick();
        for (int j = 0; j < 10; j++) chk($sformatf("reset_out%0d", j+1), no[j], 16'h0000);
        rst = 1'b1;

        // Pass-through, including one-edge latency check
        zero_all();
        hw1[0] = 16'h0100; ow[0][0] = 16'h0100; f1 = 16'h0080;
        tick();
        chk("pass_lat1", no[0], 16'h0000);
        tick();
        chk("pass_out1", no[0], 16'h0080);
        for (int j = 1; j < 10; j++) chk($sformatf("pass_out%0d", j+1), no[j], 16'h0000);

        // ReLU clamps h1, biases pass straight through
        zero_all();
        hw1[0] = 16'hFF00; f1 = 16'h0100; ow[0][0] = 16'h0100;
        ob[0] = 16'h0040; ob[1] = 16'hFFC0;
        tick(); tick();
        chk("relu_out1", no[0], 16'h0040);
        chk("relu_out2", no[1], 16'hFFC0);

        // Positive and negative saturation
        zero_all();
        hw1[0] = 16'h6400; f1 = 16'h6400; ow[0][0] = 16'h0100;
        tick(); tick();
        chk("sat_pos", no[0], 16'h7FFF);
        ow[0][0] = 16'hFF00; ob[0] = 16'hFF00;
        tick(); tick();
        chk("sat_neg", no[0], 16'h8000);

        // Floor versus round
        zero_all();
        f1 = 16'h0100; hw1[0] = 16'h0100; ow[0][0] = 16'hFFFF;
        tick(); tick();
        chk("floor_neg", no[0], 16'hFFFF);
        f1 = 16'h0001; hw1[0] = 16'h0080; ow[0][0] = 16'h0100;
        tick(); tick();
`ifdef VFR_NN_ROUND_EN
        chk("half_lsb", no[0], 16'h0001);
`else
        chk("half_lsb", no[0], 16'h0000);
`endif

        // One new sample per cycle, seen exactly two edges later
        zero_all();
        hw1[0] = 16'h0100; ow[0][0] = 16'h0100;
        tick(); tick();
        for (int i = 0; i < 7; i++) begin
            f1 = thr_in[i];
            tick();
            chk($sformatf("thru_%0d", i), no[0], (i >= 1) ? thr_in[i-1] : 16'h0000);
        end

        // All hidden neurons, f2 path and every output weight/bias mapping
        zero_all();
        f1 = 16'h0100; f2 = 16'h0200;
        hw1[0] = 16'h0100;
        hw2[1] = 16'h0100;
        hb[2]  = 16'h0100;
        hw1[3] = 16'h0100; hw2[3] = 16'hFF80; hb[3] = 16'h0080;
        for (int j = 0; j < 10; j++) begin
            ow[j][j % 4] = 16'h0100;
            ob[j] = 16'(j);
        end
        tick(); tick();
        for (int j = 0; j < 10; j++) chk($sformatf("mix_out%0d", j+1), no[j], mix_exp[j]);

        // Asynchronous reset between edges, then recovery
        #2 rst = 1'b0;
        #1;
        for (int j = 0; j < 10; j++) chk($sformatf("arst_out%0d", j+1), no[j], 16'h0000);
        tick();
        chk("arst_hold2", no[1], 16'h0000);
        rst = 1'b1;
        tick();
        chk("arst_rel1", no[0], 16'h0000);
        tick();
        for (int j = 0; j < 10; j++) chk($sformatf("arst_rec%0d", j+1), no[j], mix_exp[j]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
